i2s_rx_framer: RTL
==================

# i2s_rx_framer

Downstream stage of the I2S/TDM ADC receiver PHY, in the `bclk` domain. Consumes the PHY's per-slot word stream (valid/data/last, no backpressure) and locks onto TDM frame boundaries. Formats each slot word (left-justified or sign-extended) and buffers whole frames in a FIFO. Presents them on an AXI-Stream master with backpressure and a slot index. Frames that cannot fit in the FIFO are dropped atomically, so downstream never sees a partial frame from overflow.

## Interface
- DEPTH, 64, FIFO depth in words; power of two, ≥ 32.
- bclk  in  1  sole clock.
- rst  in  1  reset; synchronous, active-high.
- s_axis_tvalid  in  1  slot word valid, single-cycle pulse from PHY.
- s_axis_tdata  in  32  slot word; bits [word_width-1:0] valid, MSB at bit word_width-1.
- s_axis_tlast  in  1  last slot of frame.
- m_axis_tvalid  out  1  output word valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  32  formatted word.
- m_axis_tuser  out  5  slot index 0..tdm_num-1.
- m_axis_tlast  out  1  last word of frame.
- i_tdm_num  in  5  slots per frame; 0 treated as 1; bclk-synchronous, latched at slot 0.
- i_word_width  in  6  bits per slot; 0 or >32 treated as 32; latched at slot 0.
- i_sign_extend  in  1  0: left-justify to bit 31, zero-fill LSBs; 1: right-justify, sign-extend from bit word_width-1; latched at slot 0.
- o_locked  out  1  state is RUN.
- o_frame_num  out  32  frames accepted into FIFO, wraps.
- o_drop_num  out  16  frames dropped for lack of space, saturates at 0xFFFF.
- o_err_num  out  16  framing errors, saturates at 0xFFFF.

## Operation
- States: HUNT (reset state) and RUN.
- HUNT: discard all words. A valid word with tlast=1 moves to RUN with slot=0 on the next cycle.
- RUN, slot 0 valid word: latch config (tdm_num_l, width_l, sext_l). Admission check: accept the frame if free ≥ tdm_num_l, else drop it. free = DEPTH − (FIFO occupancy + format-stage word pending); reads in the same cycle are not credited. Accept increments o_frame_num; drop increments o_drop_num. The decision holds for every slot of the frame.
- Words of accepted frames are formatted and written with tuser=slot and tlast=s_axis_tlast. Words of dropped frames are discarded.
- Slot advance: slot+1 on each valid word; slot returns to 0 after tlast.
- Framing error A, tlast=1 at slot < tdm_num_l−1: o_err_num++. Word written (if accepted) with tlast=1. Slot→0, remain RUN.
- Framing error B, slot = tdm_num_l−1 with tlast=0: o_err_num++. Word written (if accepted) with forced tlast=1. Go to HUNT.
- Format:
  - Mode 0: tdata = in << (32−width_l).
  - Mode 1: tdata = in[width_l−1:0] sign-extended to 32 bits.
  - width 32 passes unchanged in both modes.
- Output: standard AXIS. Word transfers when tvalid & tready. tdata, tuser and tlast are stable while tvalid=1 and tready=0.
- Because admission reserves space, the FIFO write never occurs while the FIFO is full. The bench asserts this.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0, o_locked=0, all counters 0, FIFO empty, state HUNT.
- Reset mid-operation: FIFO contents discarded and tvalid=0 the cycle after reset is sampled high.
- Latency: input valid at edge N → format register at N+1 → FIFO write → m_axis_tvalid=1 after edge N+2, with FIFO empty and tready=1.
- Throughput: one word per cycle both in and out. Simultaneous FIFO read and write at any occupancy, including full-with-read and empty-with-write (no bypass beyond the stated latency).
- Counters and o_locked update on the edge after the triggering input word.
- HUNT→RUN: the word carrying tlast is never output. The next valid word is slot 0.

## Test plan
- tdm_num=4, width=24, sext=0, tready=1, two clean frames with data 0x00ABCDEF → 8 outputs, each tdata=0xABCDEF00, tuser 0..3, tlast on slot 3; o_frame_num=2; first output 2 cycles after first accepted input.
- sext=1, width=16, input 0x00008001 → tdata=0xFFFF8001; input 0x00007FFF → 0x00007FFF; width=0 with input 0x12345678 → 0x12345678.
- DEPTH=64, tdm_num=8, tready=0 for 10 frames → 8 frames accepted, o_drop_num=2, tvalid held with stable data. Then tready=1 → exactly 64 words, each frame complete with tlast.
- Startup: 2 words without tlast, then a tlast word → no output, o_locked=1 one cycle after the tlast word; the next frame is output normally.
- tdm_num=4, tlast at slot 1 → o_err_num=1, slot-1 output with tlast=1, next word tuser=0. Then 4 words without tlast → o_err_num=2, slot-3 word tlast=1, o_locked=0.
- Assert rst mid-frame with FIFO half full → next cycle tvalid=0, counters 0, HUNT; recovery after next tlast.

Source files
------------

// File: rtl/i2s_rx_framer.sv
// TDM frame locker and formatter for the I2S/TDM receive path.
// Locks onto frame boundaries, formats slot words, buffers whole frames and streams them out on AXIS.
module i2s_rx_framer #(
    parameter int DEPTH = 64
) (
    input  logic        bclk,
    input  logic        rst,
    input  logic        s_axis_tvalid,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic [4:0]  m_axis_tuser,
    output logic        m_axis_tlast,
    input  logic [4:0]  i_tdm_num,
    input  logic [5:0]  i_word_width,
    input  logic        i_sign_extend,
    output logic        o_locked,
    output logic [31:0] o_frame_num,
    output logic [15:0] o_drop_num,
    output logic [15:0] o_err_num
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 38;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [4:0]    r_slot;
    logic [4:0]    r_tdm_num_l;
    logic [5:0]    r_width_l;
    logic          r_sext_l;
    logic          r_accept;

    logic          r_fmt_valid;
    logic [31:0]   r_fmt_data;
    logic [4:0]    r_fmt_user;
    logic          r_fmt_last;

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic [31:0]   r_frame_num;
    logic [15:0]   r_drop_num;
    logic [15:0]   r_err_num;

    logic          w_run_word;
    logic          w_slot0;
    logic [4:0]    w_tdm_in;
    logic [5:0]    w_width_in;
    logic [4:0]    w_tdm_eff;
    logic [5:0]    w_width_eff;
    logic          w_sext_eff;
    logic          w_at_last_slot;
    logic          w_err_a;
    logic          w_err_b;
    logic [AW:0]   w_free;
    logic          w_admit;
    logic          w_accept;
    logic          w_fmt_wr;
    logic [5:0]    w_shift;
    logic [31:0]   w_shl;
    logic signed [31:0] w_sra;
    logic [31:0]   w_fmt_data;
    logic          w_fifo_rd;
    logic [EW-1:0] w_rd_word;

    // Slot 0 uses the live configuration; later slots use what slot 0 latched.
    assign w_run_word     = (r_state == ST_RUN) && s_axis_tvalid;
    assign w_slot0        = (r_slot == 5'd0);
    assign w_tdm_in       = (i_tdm_num == 5'd0) ? 5'd1 : i_tdm_num;
    assign w_width_in     = ((i_word_width == 6'd0) || (i_word_width > 6'd32)) ? 6'd32 : i_word_width;
    assign w_tdm_eff      = w_slot0 ? w_tdm_in   : r_tdm_num_l;
    assign w_width_eff    = w_slot0 ? w_width_in : r_width_l;
    assign w_sext_eff     = w_slot0 ? i_sign_extend : r_sext_l;
    assign w_at_last_slot = (r_slot == (w_tdm_eff - 5'd1));
    assign w_err_a        = s_axis_tlast && !w_at_last_slot;
    assign w_err_b        = !s_axis_tlast && w_at_last_slot;

    // Space still held by the format stage counts as used; a same-cycle read does not free space.
    assign w_free   = DEPTH_C - r_count - {{AW{1'b0}}, r_fmt_valid};
    assign w_admit  = (w_free >= (AW+1)'(w_tdm_in));
    assign w_accept = w_slot0 ? w_admit : r_accept;
    assign w_fmt_wr = w_run_word && w_accept;

    // Left-justify first; an arithmetic shift back gives the sign-extended form.
    assign w_shift    = 6'd32 - w_width_eff;
    assign w_shl      = s_axis_tdata << w_shift;
    assign w_sra      = $signed(w_shl) >>> w_shift;
    assign w_fmt_data = w_sext_eff ? w_sra : w_shl;

    always_ff @(posedge bclk) begin
        if (rst) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_HUNT: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (s_axis_tvalid && w_err_b) begin
                    w_state_next = ST_HUNT;
                end
            end
            default: w_state_next = ST_HUNT;
        endcase
    end

    always_comb begin
        o_locked = (r_state == ST_RUN);
    end

    always_ff @(posedge bclk) begin
        if (rst) begin
            r_slot      <= 5'd0;
            r_tdm_num_l <= 5'd1;
            r_width_l   <= 6'd32;
            r_sext_l    <= 1'b0;
            r_accept    <= 1'b0;
        end else if (r_state == ST_HUNT) begin
            r_slot <= 5'd0;
        end else if (s_axis_tvalid) begin
            if (w_slot0) begin
                r_tdm_num_l <= w_tdm_in;
                r_width_l   <= w_width_in;
                r_sext_l    <= i_sign_extend;
                r_accept    <= w_admit;
            end
            if (s_axis_tlast || w_err_b) begin
                r_slot <= 5'd0;
            end else begin
                r_slot <= r_slot + 5'd1;
            end
        end
    end

    always_ff @(posedge bclk) begin
        if (rst) begin
            r_frame_num <= 32'd0;
            r_drop_num  <= 16'd0;
            r_err_num   <= 16'd0;
        end else if (w_run_word) begin
            if (w_slot0) begin
                if (w_admit) begin
                    r_frame_num <= r_frame_num + 32'd1;
                end else if (r_drop_num != 16'hFFFF) begin
                    r_drop_num <= r_drop_num + 16'd1;
                end
            end
            if ((w_err_a || w_err_b) && (r_err_num != 16'hFFFF)) begin
                r_err_num <= r_err_num + 16'd1;
            end
        end
    end

    always_ff @(posedge bclk) begin
        if (rst) begin
            r_fmt_valid <= 1'b0;
            r_fmt_data  <= 32'd0;
            r_fmt_user  <= 5'd0;
            r_fmt_last  <= 1'b0;
        end else begin
            r_fmt_valid <= w_fmt_wr;
            if (w_fmt_wr) begin
                r_fmt_data <= w_fmt_data;
                r_fmt_user <= r_slot;
                r_fmt_last <= s_axis_tlast || w_err_b;
            end
        end
    end

    // Admission reserves space, so the format stage never writes into a full FIFO.
    always_ff @(posedge bclk) begin
        if (r_fmt_valid) begin
            r_mem[r_wr_ptr] <= {r_fmt_data, r_fmt_user, r_fmt_last};
        end
    end

    assign w_fifo_rd = m_axis_tvalid && m_axis_tready;
    assign w_rd_word = r_mem[r_rd_ptr];

    always_ff @(posedge bclk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (r_fmt_valid) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_fifo_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({r_fmt_valid, w_fifo_rd})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head word is held at the read pointer until taken, so the payload is stable under backpressure.
    always_comb begin
        m_axis_tvalid = (r_count != '0);
        m_axis_tdata  = 32'd0;
        m_axis_tuser  = 5'd0;
        m_axis_tlast  = 1'b0;
        if (m_axis_tvalid) begin
            m_axis_tdata = w_rd_word[37:6];
            m_axis_tuser = w_rd_word[5:1];
            m_axis_tlast = w_rd_word[0];
        end
    end

    assign o_frame_num = r_frame_num;
    assign o_drop_num  = r_drop_num;
    assign o_err_num   = r_err_num;

endmodule
